// File: rtl/mul_pipe_mac.sv
// Pipelined signed/unsigned multiplier with running accumulator and valid/ready backpressure.
// Define MUL_PIPE_MAC_SAT_EN to clamp signed accumulate overflow and report it on out_sat.
module mul_pipe_mac #(
  parameter int A_BITLEN   = 17,
  parameter int B_BITLEN   = 17,
  parameter int STAGES     = 3,
  parameter int ACC_BITLEN = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_BITLEN-1:0]   in_a,
  input  logic [B_BITLEN-1:0]   in_b,
  input  logic                  in_signed,
  input  logic                  in_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_BITLEN-1:0] out_p,
  output logic                  out_sat
);

  localparam int PW  = A_BITLEN + B_BITLEN;
  localparam int MID = STAGES - 2;

  generate
    if (ACC_BITLEN < PW) begin : g_acc_width_check
      $error("mul_pipe_mac: ACC_BITLEN must be >= A_BITLEN + B_BITLEN");
    end
    if (STAGES < 2 || STAGES > 8) begin : g_stages_check
      $error("mul_pipe_mac: STAGES must be in 2..8");
    end
  endgenerate

  function automatic logic signed [PW-1:0] ext_a(input logic [A_BITLEN-1:0] v, input logic sgn);
    return {{B_BITLEN{sgn & v[A_BITLEN-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] ext_b(input logic [B_BITLEN-1:0] v, input logic sgn);
    return {{A_BITLEN{sgn & v[B_BITLEN-1]}}, v};
  endfunction

  function automatic logic signed [ACC_BITLEN-1:0] ext_acc(input logic signed [PW-1:0] p, input logic sgn);
    logic signed [ACC_BITLEN-1:0] r;
    r = {ACC_BITLEN{sgn & p[PW-1]}};
    r[PW-1:0] = p;
    return r;
  endfunction

`ifdef MUL_PIPE_MAC_SAT_EN
  // Returns {overflow, value}; overflow only possible when both addends share a sign.
  function automatic logic [ACC_BITLEN:0] sat_add(input logic signed [ACC_BITLEN-1:0] a,
                                                  input logic signed [ACC_BITLEN-1:0] x,
                                                  input logic en);
    logic signed [ACC_BITLEN-1:0] s;
    logic ovf;
    s   = a + x;
    ovf = en && (a[ACC_BITLEN-1] == x[ACC_BITLEN-1]) && (s[ACC_BITLEN-1] != a[ACC_BITLEN-1]);
    if (ovf) s = {a[ACC_BITLEN-1], {(ACC_BITLEN-1){~a[ACC_BITLEN-1]}}};
    return {ovf, s};
  endfunction
`endif

  logic stall;
  logic advance;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;

  // ---- stage 1: operand registers ----
  logic [A_BITLEN-1:0] a_p0;
  logic [B_BITLEN-1:0] b_p0;
  logic                sgn_p0;
  logic                accm_p0;
  logic                vld_p0;

  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else if (advance) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      a_p0    <= in_a;
      b_p0    <= in_b;
      sgn_p0  <= in_signed;
      accm_p0 <= in_acc;
    end
  end

  logic signed [PW-1:0] prod_c;
  assign prod_c = ext_a(a_p0, sgn_p0) * ext_b(b_p0, sgn_p0);

  // ---- stages 2..STAGES-1: product delay line ----
  logic signed [PW-1:0] fin_prod;
  logic                 fin_sgn;
  logic                 fin_accm;
  logic                 fin_vld;

  generate
    if (MID == 0) begin : g_direct
      assign fin_prod = prod_c;
      assign fin_sgn  = sgn_p0;
      assign fin_accm = accm_p0;
      assign fin_vld  = vld_p0;
    end else begin : g_mid
      logic signed [PW-1:0] prod_pm [MID];
      logic                 sgn_pm  [MID];
      logic                 accm_pm [MID];
      logic                 vld_pm  [MID];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < MID; i++) vld_pm[i] <= 1'b0;
        end else if (advance) begin
          vld_pm[0] <= vld_p0;
          for (int i = 1; i < MID; i++) vld_pm[i] <= vld_pm[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          prod_pm[0] <= prod_c;
          sgn_pm[0]  <= sgn_p0;
          accm_pm[0] <= accm_p0;
          for (int i = 1; i < MID; i++) begin
            prod_pm[i] <= prod_pm[i-1];
            sgn_pm[i]  <= sgn_pm[i-1];
            accm_pm[i] <= accm_pm[i-1];
          end
        end
      end

      assign fin_prod = prod_pm[MID-1];
      assign fin_sgn  = sgn_pm[MID-1];
      assign fin_accm = accm_pm[MID-1];
      assign fin_vld  = vld_pm[MID-1];
    end
  endgenerate

  // ---- final stage: accumulate and output register ----
  logic signed [ACC_BITLEN-1:0] acc_r;
  logic signed [ACC_BITLEN-1:0] addend_c;
  logic signed [ACC_BITLEN-1:0] base_c;
  logic signed [ACC_BITLEN-1:0] res_c;
  logic                         sat_c;

  assign addend_c = ext_acc(fin_prod, fin_sgn);
  assign base_c   = fin_accm ? acc_r : '0;

`ifdef MUL_PIPE_MAC_SAT_EN
  logic [ACC_BITLEN:0] sum_c;
  assign sum_c = sat_add(base_c, addend_c, fin_accm & fin_sgn);
  assign res_c = sum_c[ACC_BITLEN-1:0];
  assign sat_c = sum_c[ACC_BITLEN];
`else
  assign res_c = base_c + addend_c;
  assign sat_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_sat   <= 1'b0;
      acc_r     <= '0;
    end else if (advance) begin
      out_valid <= fin_vld;
      if (fin_vld) begin
        out_p   <= res_c;
        out_sat <= sat_c;
        acc_r   <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_mac.sv
// Self-checking bench for mul_pipe_mac: directed plan scenarios plus randomized traffic vs a reference model.
module tb_mul_pipe_mac;
  localparam int AW = 17;
  localparam int BW = 17;
  localparam int ACCW = 48;
  localparam int ACCW2 = 36;
`ifdef MUL_PIPE_MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, in_signed, in_acc, out_valid, out_ready, out_sat;
  logic [AW-1:0]   in_a;
  logic [BW-1:0]   in_b;
  logic [ACCW-1:0] out_p;
  logic             in_valid2, in_ready2, out_valid2, out_ready2, out_sat2;
  logic [ACCW2-1:0] out_p2;

  mul_pipe_mac #(.A_BITLEN(AW), .B_BITLEN(BW), .STAGES(3), .ACC_BITLEN(ACCW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_sat(out_sat));

  mul_pipe_mac #(.A_BITLEN(AW), .B_BITLEN(BW), .STAGES(3), .ACC_BITLEN(ACCW2)) dut36 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_p(out_p2), .out_sat(out_sat2));

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] model_acc;

  logic [AW-1:0]   qa[$];
  logic [BW-1:0]   qb[$];
  bit              qs[$];
  bit              qc[$];
  logic [ACCW-1:0] got_p[$];
  bit              got_sat[$];
  int              rdy_err, stab_err;
  bit              tmo;

  // Exact integer arithmetic on the beat's interpreted operand values, reduced to accw bits.
  function automatic void model_beat(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                     input bit sgn, input bit accf, input int accw,
                                     inout logic [63:0] acc, output logic [63:0] res, output bit sat);
    longint pa, pb, p, sa, s, lim;
    logic [63:0] mask;
    pa = sgn ? longint'($signed(a)) : longint'({1'b0, a});
    pb = sgn ? longint'($signed(b)) : longint'({1'b0, b});
    p = pa * pb;
    mask = (64'd1 << accw) - 64'd1;
    lim = longint'(64'd1 << (accw - 1));
    sat = 1'b0;
    if (!accf) begin
      res = 64'(p) & mask;
    end else if (sgn && SAT_EN) begin
      sa = acc[accw-1] ? longint'(acc) - 2 * lim : longint'(acc);
      s = sa + p;
      if (s > lim - 1) begin s = lim - 1; sat = 1'b1; end
      else if (s < -lim) begin s = -lim; sat = 1'b1; end
      res = 64'(s) & mask;
    end else begin
      res = (acc + 64'(p)) & mask;
    end
    acc = res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_acc = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_acc = '0;
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qs.delete(); qc.delete();
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input logic [BW-1:0] b, input bit s, input bit c);
    qa.push_back(a); qb.push_back(b); qs.push_back(s); qc.push_back(c);
  endtask

  // Drives the queued beats and records what leaves the output port; mode 0 = no stall,
  // 1 = out_ready pattern 1,0,0 repeating, 2 = random out_ready and random input gaps.
  task automatic run_stream(input int mode);
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [ACCW-1:0] held = '0;
    got_p.delete(); got_sat.delete(); rdy_err = 0; stab_err = 0; tmo = 1'b0;
    while (got_p.size() < qa.size()) begin
      if (cyc >= 4000) begin tmo = 1'b1; break; end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (idx < qa.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (idx < qa.size()) begin
        in_a = qa[idx]; in_b = qb[idx]; in_signed = qs[idx]; in_acc = qc[idx];
      end
      #1;
      if (in_ready !== !(out_valid && !out_ready)) rdy_err++;
      if (prev_stall && (out_valid !== 1'b1 || out_p !== held)) stab_err++;
      if (out_valid && out_ready) begin got_p.push_back(out_p); got_sat.push_back(out_sat); end
      if (in_valid && in_ready) idx++;
      prev_stall = out_valid && !out_ready;
      held = out_p;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_p !== '0) begin n_fail++; $display("FAIL reset_out_p: got %0d expected 0", out_p); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    logic [ACCW-1:0] exp_p = 48'd17179607041;
    int rdy_low = 0;
    do_reset();
    in_valid = 1'b1; in_a = 17'h1FFFF; in_b = 17'h1FFFF; in_signed = 1'b0; in_acc = 1'b0;
    #1;
    if (in_ready !== 1'b1) rdy_low++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge1_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) rdy_low++;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge2_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) rdy_low++;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_edge3_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_p !== exp_p) begin n_fail++; $display("FAIL lat_max_unsigned: got %0d expected %0d", out_p, exp_p); end
    if (in_ready !== 1'b1) rdy_low++;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_single_beat: got %b expected 0", out_valid); end
    n_checks++; if (rdy_low !== 0) begin n_fail++; $display("FAIL lat_in_ready: got %0d low cycles expected 0", rdy_low); end
  endtask

  task automatic test_signed();
    logic [ACCW-1:0] exp [2];
    exp[0] = 48'd4294967296;
    exp[1] = 48'hFFFF_FFFF_FFFB;
    do_reset(); clear_q();
    push_beat(17'h10000, 17'h10000, 1'b1, 1'b0);
    push_beat(17'h1FFFF, 17'd5, 1'b1, 1'b0);
    run_stream(0);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL signed_timeout: got %0d results expected 2", got_p.size()); end
    for (int i = 0; i < got_p.size(); i++) begin
      n_checks++; if (got_p[i] !== exp[i]) begin n_fail++; $display("FAIL signed_result[%0d]: got %0d expected %0d", i, got_p[i], exp[i]); end
    end
  endtask

  task automatic test_acc_chain();
    logic [ACCW-1:0] exp [3];
    exp[0] = 48'd12; exp[1] = 48'd42; exp[2] = 48'd98;
    do_reset(); clear_q();
    push_beat(17'd3, 17'd4, 1'b0, 1'b0);
    push_beat(17'd5, 17'd6, 1'b0, 1'b1);
    push_beat(17'd7, 17'd8, 1'b0, 1'b1);
    run_stream(0);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL chain_timeout: got %0d results expected 3", got_p.size()); end
    for (int i = 0; i < got_p.size(); i++) begin
      n_checks++; if (got_p[i] !== exp[i]) begin n_fail++; $display("FAIL chain_result[%0d]: got %0d expected %0d", i, got_p[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(); clear_q();
    for (int i = 0; i < 10; i++) push_beat(AW'(i), 17'd2, 1'b0, 1'b0);
    run_stream(1);
    n_checks++; if (got_p.size() !== 10) begin n_fail++; $display("FAIL bp_count: got %0d expected 10", got_p.size()); end
    for (int i = 0; i < got_p.size(); i++) begin
      n_checks++; if (got_p[i] !== ACCW'(2 * i)) begin n_fail++; $display("FAIL bp_result[%0d]: got %0d expected %0d", i, got_p[i], 2 * i); end
    end
    n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d bad cycles expected 0", rdy_err); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", stab_err); end
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    do_reset();
    in_valid = 1'b1; in_a = 17'd4; in_b = 17'd5; in_signed = 1'b0; in_acc = 1'b1;
    tick();
    in_a = 17'd6; in_b = 17'd7;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_acc = '0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_output: got %0d valid cycles expected 0", seen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    clear_q();
    push_beat(17'd2, 17'd3, 1'b0, 1'b1);
    run_stream(0);
    n_checks++; if (got_p.size() !== 1) begin n_fail++; $display("FAIL midreset_count: got %0d expected 1", got_p.size()); end
    else begin
      n_checks++; if (got_p[0] !== 48'd6) begin n_fail++; $display("FAIL midreset_acc_cleared: got %0d expected 6", got_p[0]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] res;
    bit sat;
    int bad = 0;
    do_reset(); clear_q();
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      case ($urandom_range(0, 3))
        0: a = 17'h1FFFF;
        1: a = 17'h10000;
        default: a = AW'($urandom);
      endcase
      b = ($urandom_range(0, 4) == 0) ? 17'h10000 : BW'($urandom);
      push_beat(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_stream(2);
    n_checks++; if (got_p.size() !== 60) begin n_fail++; $display("FAIL rand_count: got %0d expected 60", got_p.size()); end
    for (int i = 0; i < got_p.size(); i++) begin
      model_beat(qa[i], qb[i], qs[i], qc[i], ACCW, model_acc, res, sat);
      n_checks++;
      if (got_p[i] !== res[ACCW-1:0] || got_sat[i] !== sat) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: got %0d sat %b expected %0d sat %b", i, got_p[i], got_sat[i], res[ACCW-1:0], sat);
      end
    end
    n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL rand_in_ready: got %0d bad cycles expected 0", rdy_err); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL rand_hold_stable: got %0d bad cycles expected 0", stab_err); end
  endtask

  task automatic test_sat36();
    logic [ACCW2-1:0] g_p [$];
    bit g_s [$];
    logic [63:0] acc2 = '0;
    logic [63:0] res;
    bit sat;
    logic [ACCW2-1:0] final_exp;
    do_reset();
    final_exp = SAT_EN ? 36'd34359738367 : 36'h8_0000_0000;
    in_a = 17'h10000; in_b = 17'h10000; in_signed = 1'b1; in_acc = 1'b1; out_ready2 = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      in_valid2 = (cyc < 8);
      if (out_valid2) begin g_p.push_back(out_p2); g_s.push_back(out_sat2); end
      tick();
    end
    in_valid2 = 1'b0;
    n_checks++; if (g_p.size() !== 8) begin n_fail++; $display("FAIL sat36_count: got %0d expected 8", g_p.size()); end
    for (int i = 0; i < g_p.size(); i++) begin
      model_beat(17'h10000, 17'h10000, 1'b1, 1'b1, ACCW2, acc2, res, sat);
      n_checks++;
      if (g_p[i] !== res[ACCW2-1:0] || g_s[i] !== sat) begin
        n_fail++;
        $display("FAIL sat36_step[%0d]: got %0d sat %b expected %0d sat %b", i, g_p[i], g_s[i], res[ACCW2-1:0], sat);
      end
    end
    if (g_p.size() == 8) begin
      n_checks++; if (g_p[7] !== final_exp) begin n_fail++; $display("FAIL sat36_final: got %0d expected %0d", g_p[7], final_exp); end
      n_checks++; if (g_s[7] !== SAT_EN) begin n_fail++; $display("FAIL sat36_flag: got %b expected %b", g_s[7], SAT_EN); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_acc_chain();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_sat36();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
